// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (instruction fetch / data) arbiter in front of a
//                single-outstanding memory interface.  Each port latches one
//                request into a pending slot.  An IDLE/ISSUE/WAIT FSM grants
//                one pending port at a time, drives a one-cycle memExecute
//                strobe, and waits for memDataReady.  If the memory stays
//                silent for TIMEOUT_CYCLES cycles, the FSM aborts the access
//                with a busError pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FAIR            1: alternate the grant on contention, 0: data port wins
//    TIMEOUT_CYCLES  WAIT cycles before the access is aborted (1..65535)
//  Ports
//    clk, reset                 rising-edge clock, async active-low reset
//    fetch*                     read-only request port, done pulse, read data
//    data*                      load/store request port, done pulse, read data
//    mem*                       downstream memory command/response
//    busError                   one-cycle pulse on a timed-out access
//    grantOwner                 current/last owner (0 = fetch, 1 = data)
// ============================================================================
module mem_arbiter #(
  parameter int FAIR           = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  // fetch port
  input  logic        fetchExecute,
  input  logic [31:0] fetchAddr,
  output logic        fetchReady,
  output logic        fetchDone,
  output logic [31:0] fetchData,

  // data port
  input  logic        dataExecute,
  input  logic [31:0] dataAddr,
  input  logic        dataWrEn,
  input  logic [31:0] dataWrData,
  input  logic [3:0]  dataByteEn,
  output logic        dataPortReady,
  output logic        dataPortDone,
  output logic [31:0] dataPortRdata,

  // memory side
  input  logic        memReady,
  input  logic        memDataReady,
  input  logic [31:0] memRdata,
  output logic        memExecute,
  output logic [31:0] memAddr,
  output logic        memWrEn,
  output logic [31:0] memWrData,
  output logic [3:0]  memByteEn,

  // status
  output logic        busError,
  output logic        grantOwner
);

  // Last WAIT count value before the abort fires: entering WAIT clears the
  // counter, so the abort edge is reached after exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q;

  // pending slots and latched command fields
  logic        fetch_pend_q;
  logic        fetch_pend_d;
  logic [31:0] fetch_addr_q;
  logic        data_pend_q;
  logic        data_pend_d;
  logic [31:0] data_addr_q;
  logic        data_wren_q;
  logic [31:0] data_wrdata_q;
  logic [3:0]  data_byteen_q;

  logic [15:0] wait_cnt_q;

  // combinational helpers
  logic        fetch_accept;
  logic        data_accept;
  logic        wait_done;
  logic        wait_tmo;
  logic        xfer_end;
  logic        owner_d;

  // A port is ready whenever its single pending slot is free.
  assign fetchReady    = !fetch_pend_q;
  assign dataPortReady = !data_pend_q;

  always_comb begin
    fetch_accept = fetchExecute && !fetch_pend_q;
    data_accept  = dataExecute  && !data_pend_q;

    // memDataReady is only meaningful while waiting; elsewhere it is ignored.
    wait_done = (state_q == ST_WAIT) && memDataReady;
    wait_tmo  = (state_q == ST_WAIT) && !memDataReady && (wait_cnt_q == TMO_LAST);
    xfer_end  = wait_done || wait_tmo;

    // Set and clear never collide: accepting needs the slot empty, while
    // retiring needs it full.  A strobe coinciding with the done edge is
    // therefore dropped, because the slot still reads as full on that edge.
    fetch_pend_d = fetch_pend_q;
    if (fetch_accept) begin
      fetch_pend_d = 1'b1;
    end else if (xfer_end && !grantOwner) begin
      fetch_pend_d = 1'b0;
    end

    data_pend_d = data_pend_q;
    if (data_accept) begin
      data_pend_d = 1'b1;
    end else if (xfer_end && grantOwner) begin
      data_pend_d = 1'b0;
    end

    // Owner selection.  grantOwner doubles as the last-grant record, so in
    // fair mode the port that was not served last wins a contention.
    if (fetch_pend_q && data_pend_q) begin
      owner_d = (FAIR != 0) ? !grantOwner : 1'b1;
    end else begin
      owner_d = data_pend_q;
    end
  end

  // --------------------------------------------------------------------------
  // Pending slots and command capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pend_q  <= 1'b0;
      fetch_addr_q  <= '0;
      data_pend_q   <= 1'b0;
      data_addr_q   <= '0;
      data_wren_q   <= 1'b0;
      data_wrdata_q <= '0;
      data_byteen_q <= '0;
    end else begin
      fetch_pend_q <= fetch_pend_d;
      data_pend_q  <= data_pend_d;
      if (fetch_accept) begin
        fetch_addr_q <= fetchAddr;
      end
      if (data_accept) begin
        data_addr_q   <= dataAddr;
        data_wren_q   <= dataWrEn;
        data_wrdata_q <= dataWrData;
        data_byteen_q <= dataByteEn;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      memExecute    <= 1'b0;
      memAddr       <= '0;
      memWrEn       <= 1'b0;
      memWrData     <= '0;
      memByteEn     <= '0;
      fetchDone     <= 1'b0;
      dataPortDone  <= 1'b0;
      busError      <= 1'b0;
      fetchData     <= '0;
      dataPortRdata <= '0;
      grantOwner    <= 1'b1;
    end else begin
      // completion strobes are single-cycle pulses
      fetchDone    <= 1'b0;
      dataPortDone <= 1'b0;
      busError     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (memReady && (fetch_pend_q || data_pend_q)) begin
            grantOwner <= owner_d;
            memExecute <= 1'b1;
            if (owner_d) begin
              memAddr   <= data_addr_q;
              memWrEn   <= data_wren_q;
              memWrData <= data_wrdata_q;
              memByteEn <= data_byteen_q;
            end else begin
              // fetches are always full-word reads
              memAddr   <= fetch_addr_q;
              memWrEn   <= 1'b0;
              memWrData <= '0;
              memByteEn <= 4'hF;
            end
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          memExecute <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (xfer_end) begin
            busError <= wait_tmo;
            // Stores also latch memRdata so the read-data output always
            // reflects the last completion of that port.
            if (grantOwner) begin
              dataPortDone  <= 1'b1;
              dataPortRdata <= wait_tmo ? ERR_RDATA : memRdata;
            end else begin
              fetchDone <= 1'b1;
              fetchData <= wait_tmo ? ERR_RDATA : memRdata;
            end
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Bench for mem_arbiter.  Two instances (FAIR=1 and FAIR=0,
//                both TIMEOUT_CYCLES=4) share every input, so each directed
//                scenario yields per-instance expectations.  A memory
//                responder answers each memExecute one cycle after it drops.
//                Completions are compared against per-instance expectation
//                queues by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        fetchExecute;
  logic [31:0] fetchAddr;
  logic        dataExecute;
  logic [31:0] dataAddr;
  logic        dataWrEn;
  logic [31:0] dataWrData;
  logic [3:0]  dataByteEn;
  logic        memReady;
  logic        memDataReady;
  logic [31:0] memRdata;

  logic [1:0]  fetchReady, fetchDone, dataPortReady, dataPortDone;
  logic [1:0]  memExecute, memWrEn, busError, grantOwner;
  logic [31:0] fetchData [2];
  logic [31:0] dataPortRdata [2];
  logic [31:0] memAddr [2];
  logic [31:0] memWrData [2];
  logic [3:0]  memByteEn [2];

  int checks   = 0;
  int failures = 0;

  // Expected completions in order: {port (1=data), busError, read data}
  logic [33:0] exp0 [$];
  logic [33:0] exp1 [$];
  logic [31:0] rsp_q [$];
  logic        rsp_en;

  mem_arbiter #(.FAIR(1), .TIMEOUT_CYCLES(4)) u_fair (
    .clk(clk), .reset(reset),
    .fetchExecute(fetchExecute), .fetchAddr(fetchAddr),
    .fetchReady(fetchReady[0]), .fetchDone(fetchDone[0]), .fetchData(fetchData[0]),
    .dataExecute(dataExecute), .dataAddr(dataAddr), .dataWrEn(dataWrEn),
    .dataWrData(dataWrData), .dataByteEn(dataByteEn),
    .dataPortReady(dataPortReady[0]), .dataPortDone(dataPortDone[0]),
    .dataPortRdata(dataPortRdata[0]),
    .memReady(memReady), .memDataReady(memDataReady), .memRdata(memRdata),
    .memExecute(memExecute[0]), .memAddr(memAddr[0]), .memWrEn(memWrEn[0]),
    .memWrData(memWrData[0]), .memByteEn(memByteEn[0]),
    .busError(busError[0]), .grantOwner(grantOwner[0])
  );

  mem_arbiter #(.FAIR(0), .TIMEOUT_CYCLES(4)) u_prio (
    .clk(clk), .reset(reset),
    .fetchExecute(fetchExecute), .fetchAddr(fetchAddr),
    .fetchReady(fetchReady[1]), .fetchDone(fetchDone[1]), .fetchData(fetchData[1]),
    .dataExecute(dataExecute), .dataAddr(dataAddr), .dataWrEn(dataWrEn),
    .dataWrData(dataWrData), .dataByteEn(dataByteEn),
    .dataPortReady(dataPortReady[1]), .dataPortDone(dataPortDone[1]),
    .dataPortRdata(dataPortRdata[1]),
    .memReady(memReady), .memDataReady(memDataReady), .memRdata(memRdata),
    .memExecute(memExecute[1]), .memAddr(memAddr[1]), .memWrEn(memWrEn[1]),
    .memWrData(memWrData[1]), .memByteEn(memByteEn[1]),
    .busError(busError[1]), .grantOwner(grantOwner[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ctrl[%0d]", k),
          {memExecute[k], memWrEn[k], fetchDone[k], dataPortDone[k], busError[k],
           grantOwner[k], fetchReady[k], dataPortReady[k]}, 64'b0000_0111);
      chk($sformatf("rst_addr[%0d]", k), memAddr[k], 0);
      chk($sformatf("rst_wdata[%0d]", k), {memWrData[k], memByteEn[k]}, 0);
      chk($sformatf("rst_rdata[%0d]", k), {fetchData[k], dataPortRdata[k]}, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Memory responder: memDataReady for one cycle, the cycle after memExecute.
  initial begin
    memDataReady = 1'b0;
    memRdata     = '0;
    forever begin
      @(negedge clk);
      if (rsp_en && memExecute[0]) begin
        @(negedge clk);
        memDataReady = 1'b1;
        memRdata     = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hBAD0_BAD0;
        @(negedge clk);
        memDataReady = 1'b0;
      end
    end
  end

  // Completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        for (int k = 0; k < 2; k++) begin
          logic [33:0] e;
          logic [34:0] got;
          logic [34:0] want;
          logic        have;
          if (fetchDone[k] || dataPortDone[k]) begin
            have = 1'b0;
            e    = '0;
            if (k == 0) begin
              if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
            end else begin
              if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
            end
            got  = {fetchDone[k], dataPortDone[k], busError[k],
                    dataPortDone[k] ? dataPortRdata[k] : fetchData[k]};
            want = {!e[33], e[33], e[32], e[31:0]};
            checks++;
            if (!have) begin
              failures++;
              $display("FAIL done_unexpected[%0d]: got %h expected no completion (t=%0t)", k, got, $time);
            end else if (got !== want) begin
              failures++;
              $display("FAIL done[%0d]: got %h expected %h (t=%0t)", k, got, want, $time);
            end
          end else if (busError[k]) begin
            checks++;
            failures++;
            $display("FAIL buserr_alone[%0d]: got 1 expected 0 (t=%0t)", k, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    fetchExecute = 1'b0;
    fetchAddr    = '0;
    dataExecute  = 1'b0;
    dataAddr     = '0;
    dataWrEn     = 1'b0;
    dataWrData   = '0;
    dataByteEn   = '0;
    memReady     = 1'b1;
    rsp_en       = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();

    // ---- Fetch only, strobed on the very first edge out of reset ----
    rsp_q.push_back(32'h0000_0013);
    exp0.push_back({1'b0, 1'b0, 32'h0000_0013});
    exp1.push_back({1'b0, 1'b0, 32'h0000_0013});
    reset        = 1'b1;
    fetchExecute = 1'b1;
    fetchAddr    = 32'h100;
    @(negedge clk);                       // after edge N
    fetchExecute = 1'b0;
    chk("f_ready_busy", fetchReady, 2'b00);
    @(negedge clk);                       // after N+1
    chk("f_exec_hi", memExecute, 2'b11);
    chk("f_addr", memAddr[0], 32'h100);
    chk("f_cmd", {memWrEn[0], memByteEn[0], grantOwner[0]}, {1'b0, 4'hF, 1'b0});
    @(negedge clk);                       // after N+2
    chk("f_exec_lo", memExecute, 2'b00);
    @(negedge clk);                       // after N+3
    chk("f_done_latency", fetchDone, 2'b11);
    @(negedge clk);
    chk("f_ready_back", {fetchDone, fetchReady}, 4'b0011);

    // ---- Simultaneous fetch + store after reset ----
    do_reset();
    rsp_q.push_back(32'h1111_1111);
    rsp_q.push_back(32'h2222_2222);
    exp0.push_back({1'b0, 1'b0, 32'h1111_1111});
    exp0.push_back({1'b1, 1'b0, 32'h2222_2222});
    exp1.push_back({1'b1, 1'b0, 32'h1111_1111});
    exp1.push_back({1'b0, 1'b0, 32'h2222_2222});
    fetchExecute = 1'b1;
    fetchAddr    = 32'h200;
    dataExecute  = 1'b1;
    dataAddr     = 32'h300;
    dataWrEn     = 1'b1;
    dataWrData   = 32'hDEAD_BEEF;
    dataByteEn   = 4'b0011;
    @(negedge clk);                       // after N
    fetchExecute = 1'b0;
    dataExecute  = 1'b0;
    chk("both_ready_busy", {fetchReady, dataPortReady}, 4'b0000);
    @(negedge clk);                       // after N+1
    chk("fair_first", {grantOwner[0], memAddr[0]}, {1'b0, 32'h200});
    chk("prio_first", {grantOwner[1], memAddr[1]}, {1'b1, 32'h300});
    chk("prio_store", {memWrEn[1], memWrData[1], memByteEn[1]}, {1'b1, 32'hDEAD_BEEF, 4'b0011});
    // strobe while pending and on the done edge: must be dropped
    fetchExecute = 1'b1;
    fetchAddr    = 32'h999;
    @(negedge clk);                       // after N+2
    @(negedge clk);                       // after N+3
    fetchExecute = 1'b0;
    chk("first_done", {fetchDone[0], dataPortDone[1]}, 2'b11);
    @(negedge clk);                       // after N+4
    chk("fair_second", {grantOwner[0], memAddr[0], memExecute[0]}, {1'b1, 32'h300, 1'b1});
    chk("fair_store", {memWrEn[0], memWrData[0], memByteEn[0]}, {1'b1, 32'hDEAD_BEEF, 4'b0011});
    chk("prio_second", {grantOwner[1], memAddr[1], memWrEn[1]}, {1'b0, 32'h200, 1'b0});
    chk("prio_fetch_cmd", {memWrData[1], memByteEn[1]}, {32'h0, 4'hF});
    repeat (4) @(negedge clk);
    chk("both_ready_idle", {fetchReady, dataPortReady}, 4'b1111);

    // ---- Timeout: memory never answers ----
    rsp_en = 1'b0;
    exp0.push_back({1'b1, 1'b1, 32'hFFFF_FFFF});
    exp1.push_back({1'b1, 1'b1, 32'hFFFF_FFFF});
    dataExecute = 1'b1;
    dataAddr    = 32'h400;
    dataWrEn    = 1'b0;
    dataByteEn  = 4'hF;
    @(negedge clk);                       // after N
    dataExecute = 1'b0;
    repeat (5) @(negedge clk);            // after N+5
    chk("tmo_early", {busError, dataPortDone}, 4'b0000);
    @(negedge clk);                       // after N+6
    chk("tmo_fire", {busError, dataPortDone}, 4'b1111);
    @(negedge clk);
    chk("tmo_after", {busError, dataPortReady}, 4'b0011);
    rsp_en = 1'b1;

    // ---- memReady held low with fetch pending ----
    memReady = 1'b0;
    rsp_q.push_back(32'h0000_0055);
    exp0.push_back({1'b0, 1'b0, 32'h0000_0055});
    exp1.push_back({1'b0, 1'b0, 32'h0000_0055});
    fetchExecute = 1'b1;
    fetchAddr    = 32'h500;
    @(negedge clk);
    fetchExecute = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall", {memExecute, fetchReady}, 4'b0000);
    end
    memReady = 1'b1;
    @(negedge clk);
    chk("stall_release", {memExecute, grantOwner}, 4'b1100);
    chk("stall_addr", memAddr[1], 32'h500);
    repeat (4) @(negedge clk);

    // ---- Reset during WAIT, then a stray memDataReady ----
    rsp_en = 1'b0;
    fetchExecute = 1'b1;
    fetchAddr    = 32'h600;
    @(negedge clk);                       // after N
    fetchExecute = 1'b0;
    repeat (3) @(negedge clk);            // after N+3, in WAIT
    reset = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge clk);
    reset        = 1'b1;
    memDataReady = 1'b1;
    memRdata     = 32'hABCD_1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_post_rst", {fetchDone, dataPortDone, busError}, 6'b0);
    end
    memDataReady = 1'b0;
    check_reset();

    // ---- Single data load right after reset: granted despite lastGrant=1 ----
    rsp_en = 1'b1;
    rsp_q.push_back(32'h6666_6666);
    exp0.push_back({1'b1, 1'b0, 32'h6666_6666});
    exp1.push_back({1'b1, 1'b0, 32'h6666_6666});
    dataExecute = 1'b1;
    dataAddr    = 32'h700;
    dataWrEn    = 1'b0;
    dataByteEn  = 4'hF;
    @(negedge clk);
    dataExecute = 1'b0;
    @(negedge clk);
    chk("single_data", {grantOwner, memAddr[0], memWrEn[0]}, {2'b11, 32'h700, 1'b0});
    repeat (5) @(negedge clk);

    chk("drain_exp0", exp0.size(), 0);
    chk("drain_exp1", exp1.size(), 0);
    chk("drain_rsp", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
